// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet checker.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        KIND_TOKEN     = 2'd0,
        KIND_DATA      = 2'd1,
        KIND_HANDSHAKE = 2'd2,
        KIND_SPECIAL   = 2'd3
    } pkt_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } rx_state_t;

    localparam int ERR_PID = 0;
    localparam int ERR_CRC = 1;
    localparam int ERR_LEN = 2;
    localparam int ERR_OVR = 3;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_PRE   = 4'hC;

    localparam logic [4:0]  CRC5_POLY   = 5'h05;
    localparam logic [4:0]  CRC5_SEED   = 5'h1F;
    localparam logic [4:0]  CRC5_RES    = 5'h0C;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_SEED  = 16'hFFFF;
    localparam logic [15:0] CRC16_RES   = 16'h800D;

    // PID type field (low two bits) selects the packet family.
    function automatic pkt_kind_t kind_of(input logic [1:0] t);
        case (t)
            2'b01:   return KIND_TOKEN;
            2'b11:   return KIND_DATA;
            2'b10:   return KIND_HANDSHAKE;
            default: return KIND_SPECIAL;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC LFSR, MSB = highest-order coefficient, with residue compare.
module usb_crc_serial #(
    parameter int            W       = 5,
    parameter logic [W-1:0]  POLY    = '0,
    parameter logic [W-1:0]  SEED    = '1,
    parameter logic [W-1:0]  RESIDUE = '0
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         din_i,
    output logic [W-1:0] crc_o,
    output logic         residue_ok_o
);

    logic [W-1:0] crc_q, crc_d;
    logic         fb;

    assign fb = din_i ^ crc_q[W-1];

    always_comb begin
        crc_d = crc_q;
        if (clr_i)
            crc_d = SEED;
        else if (en_i)
            crc_d = {crc_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) crc_q <= SEED;
        else        crc_q <= crc_d;
    end

    assign crc_o        = crc_q;
    assign residue_ok_o = (crc_q == RESIDUE);

endmodule

// File: rtl/usb_rx_pkt_checker.sv
// USB receive packet deserialiser/classifier with streaming CRC5/CRC16 check.
module usb_rx_pkt_checker
    import usb_rx_pkg::*;
#(
    parameter int  MAX_DATA_BYTES = 64,
    parameter int  LEN_W          = 11,
    parameter bit  STRICT_LEN     = 1'b1,
    localparam int PKT_W          = 8 + 8*MAX_DATA_BYTES + 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bit_in_avail,
    input  logic             bit_in,
    input  logic             eop,
    output logic             in_ready,
    output logic [PKT_W-1:0] pkt,
    output logic [LEN_W-1:0] pkt_len,
    output logic [3:0]       pid,
    output logic [1:0]       pkt_kind,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic             pkt_ok,
    output logic [3:0]       err
);

    localparam int             IDX_W  = $clog2(PKT_W);
    localparam logic [LEN_W-1:0] L_8   = LEN_W'(8);
    localparam logic [LEN_W-1:0] L_24  = LEN_W'(24);
    localparam logic [LEN_W-1:0] L_PKT = LEN_W'(PKT_W);

    rx_state_t        state_q, state_d;
    logic [PKT_W-1:0] pkt_q;
    logic [LEN_W-1:0] len_q;
    logic             chk_q, chk_d;
    logic             valid_q, ovr_q, ovr_d;
    logic [3:0]       err_q, err_d;
    pkt_kind_t        kind_q, kind_d;
    logic             acc, drop, hs;
    logic             crc5_ok, crc16_ok;
    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic             unused_crc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        acc     = 1'b0;
        drop    = 1'b0;
        hs      = 1'b0;
        case (state_q)
            ST_IDLE: if (bit_in_avail) begin
                acc     = 1'b1;
                state_d = eop ? ST_HOLD : ST_RECV;
            end
            ST_RECV: begin
                acc = bit_in_avail;
                if (eop) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                drop = bit_in_avail;
                if (valid_q && pkt_ready) begin
                    hs      = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Classification runs one cycle after eop, on the fully updated length/CRC.
    assign chk_d = (state_q != ST_HOLD) && (state_d == ST_HOLD);
    assign ovr_d = (chk_q ? 1'b0 : ovr_q) | drop;

    always_comb begin
        logic pid_err, len_err, crc_err, use5, use16;
        kind_d  = kind_of(pkt_q[1:0]);
        pid_err = (pkt_q[7:4] != ~pkt_q[3:0]) || (len_q < L_8);
        len_err = 1'b0;
        use5    = 1'b0;
        use16   = 1'b0;
        case (kind_d)
            KIND_TOKEN: begin
                len_err = STRICT_LEN && (len_q != L_24);
                use5    = 1'b1;
            end
            KIND_DATA: begin
                len_err = (len_q < L_24) || (len_q > L_PKT) || (len_q[2:0] != 3'd0);
                use16   = 1'b1;
            end
            KIND_HANDSHAKE: len_err = STRICT_LEN && (len_q != L_8);
            default: if (pkt_q[3:0] == PID_PRE) begin
                len_err = STRICT_LEN && (len_q != L_8);
            end else begin
                len_err = STRICT_LEN && (len_q != L_24);
                use5    = 1'b1;
            end
        endcase
        crc_err = !len_err && ((use5 && !crc5_ok) || (use16 && !crc16_ok));
        err_d   = {ovr_q, len_err, crc_err, pid_err};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pkt_q   <= '0;
            len_q   <= '0;
            chk_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= '0;
            kind_q  <= KIND_TOKEN;
            ovr_q   <= 1'b0;
        end else begin
            chk_q <= chk_d;
            ovr_q <= ovr_d;
            if (hs) begin
                pkt_q   <= '0;
                len_q   <= '0;
                valid_q <= 1'b0;
                err_q   <= '0;
                kind_q  <= KIND_TOKEN;
            end else begin
                if (acc) begin
                    if (len_q < L_PKT) pkt_q[len_q[IDX_W-1:0]] <= bit_in;
                    if (len_q != '1)   len_q <= len_q + 1'b1;
                end
                if (chk_q) begin
                    valid_q <= 1'b1;
                    err_q   <= err_d;
                    kind_q  <= kind_d;
                end
            end
        end
    end

    usb_crc_serial #(.W(5), .POLY(CRC5_POLY), .SEED(CRC5_SEED), .RESIDUE(CRC5_RES)) u_crc5 (
        .clk(clk), .rst_b(rst_b), .en_i(acc && (len_q >= L_8)), .clr_i(hs),
        .din_i(bit_in), .crc_o(crc5), .residue_ok_o(crc5_ok)
    );

    usb_crc_serial #(.W(16), .POLY(CRC16_POLY), .SEED(CRC16_SEED), .RESIDUE(CRC16_RES)) u_crc16 (
        .clk(clk), .rst_b(rst_b), .en_i(acc && (len_q >= L_8)), .clr_i(hs),
        .din_i(bit_in), .crc_o(crc16), .residue_ok_o(crc16_ok)
    );

    assign unused_crc = ^{crc5, crc16};

    assign in_ready  = (state_q != ST_HOLD);
    assign pkt       = pkt_q;
    assign pkt_len   = len_q;
    assign pid       = pkt_q[3:0];
    assign pkt_kind  = kind_q;
    assign pkt_valid = valid_q;
    assign pkt_ok    = valid_q && (err_q == 4'd0);
    assign err       = err_q;

endmodule
